ddr_dly_line_ctrl: RTL and testbench
====================================

// Module: ddr_dly_line_ctrl
// PURPOSE
//  Sequences the per-lane IOD dynamic delay lines (MOVE/DIRECTION/LOAD, OUT_OF_RANGE) of a DDR3 PHY
//  block (e.g. BA / ADDR lanes). Accepts one command at a time (LOAD or MOVE-by-N) from a training
//  or host engine and turns it into correctly spaced single-cycle pulses on the addressed lane.
//  Tracks a shadow tap count per lane and reports completion, steps applied and range errors.
// PARAMETERS
//  NUM_LANES   3  delay-line lanes driven (one per IOD)
//  TAP_W       8  tap counter / command count width
//  MAX_TAP   255  highest legal shadow tap value
//  INIT_TAP    1  shadow tap value after reset or LOAD; equals the IOD TX_DELAY_VAL setting
//  GAP_CYCLES  2  idle cycles after each MOVE pulse (>=1)
//  LOAD_CYCLES 1  cycles LOAD is held high (>=1)
// PORTS
//  FAB_CLK                  in   1              fabric clock; all logic on rising edge
//  SYNC_RST                 in   1              synchronous, active-high reset
//  CMD_VALID                in   1              command valid
//  CMD_READY                out  1              block idle, command accepted when VALID&READY
//  CMD_OP                   in   2              00 LOAD, 01 MOVE, 1x illegal
//  CMD_LANE                 in   $clog2(NUM_LANES)  target lane index
//  CMD_DIR                  in   1              MOVE direction, 1 = increment tap
//  CMD_COUNT                in   TAP_W          MOVE step count
//  DONE                     out  1              one-cycle completion pulse
//  DONE_STATUS              out  2              00 ok, 01 range abort, 10 illegal op/lane; valid with DONE
//  DONE_STEPS               out  TAP_W          MOVE pulses actually issued; valid with DONE
//  TAP_VAL                  out  NUM_LANES*TAP_W  shadow tap counts, lane i at [i*TAP_W +: TAP_W]
//  DELAY_LINE_MOVE          out  NUM_LANES      per-lane move pulse to IOD
//  DELAY_LINE_DIRECTION     out  NUM_LANES      per-lane direction to IOD
//  DELAY_LINE_LOAD          out  NUM_LANES      per-lane load to IOD
//  DELAY_LINE_OUT_OF_RANGE  in   NUM_LANES      per-lane range flag from IOD (same clock)
// BEHAVIOUR
//  Reset: state IDLE, CMD_READY=1, DONE=0, DONE_STATUS=0, DONE_STEPS=0, all MOVE/LOAD/DIRECTION=0,
//   every TAP_VAL lane = INIT_TAP. Reset mid-command aborts at once; no DONE is issued for it.
//  All outputs are registered. CMD_READY=1 only in IDLE. Command fields are captured on acceptance.
//  States: IDLE, SETUP, PULSE, GAP, LOADING, FINISH. Acceptance edge = cycle 0.
//  Illegal (OP=1x or LANE>=NUM_LANES): IDLE->FINISH, no pulses, DONE at cycle 1, status 10, steps 0.
//  LOAD: cycle 1..LOAD_CYCLES LOAD[lane]=1 (LOADING); FINISH: TAP_VAL[lane]=INIT_TAP, DONE,
//   status 00, steps 0. DONE is at cycle 1+LOAD_CYCLES.
//  MOVE, COUNT=0: SETUP then FINISH, DONE at cycle 2, status 00, steps 0.
//  MOVE, COUNT=N: cycle 1 SETUP drives DIRECTION[lane]=DIR. DIRECTION holds its last value after the command.
//   Each step is PULSE (MOVE[lane]=1 for exactly 1 cycle, tap +/-1) followed by GAP_CYCLES of GAP.
//   Normal DONE is at cycle 2+N*(1+GAP_CYCLES), status 00, steps N.
//  Range check, made before every PULSE (in SETUP or in the last GAP cycle):
//   abort if OUT_OF_RANGE[lane]=1, or if the tap is at MAX_TAP with DIR=1, or at 0 with DIR=0.
//   Abort goes to FINISH with no further pulse: status 01, steps = pulses already issued.
//  Only the addressed lane's MOVE/LOAD ever toggle. The tap counter never wraps.
//  CMD_VALID is ignored while not IDLE. A new command can be accepted in the cycle after DONE.
// STRUCTURE
//  Package ddr_dly_pkg: op codes (OP_LOAD, OP_MOVE), status codes (ST_OK, ST_RANGE, ST_ILLEGAL),
//   FSM state enum.
//  Single module, no sub-module. Step/gap down-counter and shadow tap array are inline.
// TESTING
//  1 Reset, then MOVE lane0 DIR=1 N=3 -> MOVE[0] pulses at cycles 2,5,8; DONE at 11; TAP_VAL[0]=4, steps 3.
//  2 LOAD lane2 after a move -> LOAD[2]=1 in cycle 1 only; DONE at 2; TAP_VAL[2]=1; no other lane toggles.
//  3 Tap=1, MOVE DIR=0 N=5 -> 1 pulse; abort before 2nd; DONE status 01, steps 1, TAP_VAL=0.
//  4 Force OUT_OF_RANGE[1]=1 after 2nd pulse, MOVE lane1 N=6 -> DONE status 01, steps 2.
//  5 OP=2'b11, then LANE=3 -> DONE at cycle 1 status 10, no pulses; COUNT=0 -> DONE at 2 status 00.
//  6 SYNC_RST at cycle 4 of N=10 move -> next cycle MOVE=0, READY=1, taps=INIT_TAP, no DONE.

Source files
------------

// File: rtl/ddr_dly_pkg.sv
// Shared op/status codes and FSM state encoding for the DDR IOD delay-line sequencer.
package ddr_dly_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOVE = 2'b01;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_RANGE   = 2'b01;
  localparam logic [1:0] ST_ILLEGAL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_LOADING,
    S_FINISH
  } state_e;

endpackage

// File: rtl/ddr_dly_line_ctrl.sv
// Turns LOAD / MOVE-by-N commands into spaced single-cycle MOVE/LOAD pulses on one IOD lane,
// keeping a shadow tap count per lane and reporting steps issued and range aborts.
module ddr_dly_line_ctrl
  import ddr_dly_pkg::*;
#(
  parameter int unsigned NUM_LANES   = 3,
  parameter int unsigned TAP_W       = 8,
  parameter int unsigned MAX_TAP     = 255,
  parameter int unsigned INIT_TAP    = 1,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned LOAD_CYCLES = 1,
  localparam int unsigned LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                       FAB_CLK,
  input  logic                       SYNC_RST,
  input  logic                       CMD_VALID,
  output logic                       CMD_READY,
  input  logic [1:0]                 CMD_OP,
  input  logic [LANE_W-1:0]          CMD_LANE,
  input  logic                       CMD_DIR,
  input  logic [TAP_W-1:0]           CMD_COUNT,
  output logic                       DONE,
  output logic [1:0]                 DONE_STATUS,
  output logic [TAP_W-1:0]           DONE_STEPS,
  output logic [NUM_LANES*TAP_W-1:0] TAP_VAL,
  output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
  input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE
);

  localparam int unsigned HOLD_MAX = (GAP_CYCLES > LOAD_CYCLES) ? GAP_CYCLES : LOAD_CYCLES;
  localparam int unsigned CNT_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;

  state_e                         state_q, state_d;
  logic [LANE_W-1:0]              lane_q, lane_d;
  logic                           dir_q, dir_d;
  logic                           is_load_q, is_load_d;
  logic [TAP_W-1:0]               cnt_q, cnt_d;
  logic [TAP_W-1:0]               steps_q, steps_d;
  logic [CNT_W-1:0]               hold_q, hold_d;
  logic [1:0]                     st_q, st_d;
  logic [NUM_LANES-1:0][TAP_W-1:0] tap_q, tap_d;
  logic [NUM_LANES-1:0]           move_q, move_d, dirl_q, dirl_d, load_q, load_d;
  logic                           ready_q, ready_d, done_q, done_d;
  logic [1:0]                     dstat_q, dstat_d;
  logic [TAP_W-1:0]               dsteps_q, dsteps_d;

  logic [NUM_LANES-1:0] lane_oh;
  logic [TAP_W-1:0]     cur_tap;
  logic                 blocked;
  logic                 decide;

  assign lane_oh = NUM_LANES'(1) << lane_q;
  assign cur_tap = tap_q[lane_q];
  // A step is refused if the IOD flags range or the shadow count sits at the end it would leave.
  assign blocked = DELAY_LINE_OUT_OF_RANGE[lane_q] |
                   (dir_q ? (cur_tap == TAP_W'(MAX_TAP)) : (cur_tap == '0));

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    dir_d     = dir_q;
    is_load_d = is_load_q;
    cnt_d     = cnt_q;
    steps_d   = steps_q;
    hold_d    = hold_q;
    st_d      = st_q;
    tap_d     = tap_q;
    dirl_d    = dirl_q;
    dstat_d   = dstat_q;
    dsteps_d  = dsteps_q;
    move_d    = '0;
    load_d    = '0;
    done_d    = 1'b0;
    decide    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          lane_d    = CMD_LANE;
          dir_d     = CMD_DIR;
          cnt_d     = CMD_COUNT;
          steps_d   = '0;
          is_load_d = 1'b0;
          st_d      = ST_OK;
          if (CMD_OP[1] || (32'(CMD_LANE) >= NUM_LANES)) begin
            st_d    = ST_ILLEGAL;
            state_d = S_FINISH;
          end else if (CMD_OP == OP_LOAD) begin
            is_load_d = 1'b1;
            hold_d    = CNT_W'(LOAD_CYCLES - 1);
            state_d   = S_LOADING;
          end else begin
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        dirl_d = (dirl_q & ~lane_oh) | (dir_q ? lane_oh : '0);
        decide = 1'b1;
      end
      S_PULSE: begin
        move_d         = lane_oh;
        tap_d[lane_q]  = dir_q ? cur_tap + 1'b1 : cur_tap - 1'b1;
        cnt_d          = cnt_q - 1'b1;
        steps_d        = steps_q + 1'b1;
        hold_d         = CNT_W'(GAP_CYCLES - 1);
        state_d        = S_GAP;
      end
      S_GAP: begin
        if (hold_q != '0) hold_d = hold_q - 1'b1;
        else              decide = 1'b1;
      end
      S_LOADING: begin
        load_d = lane_oh;
        if (hold_q != '0) hold_d  = hold_q - 1'b1;
        else              state_d = S_FINISH;
      end
      S_FINISH: begin
        done_d   = 1'b1;
        dstat_d  = st_q;
        dsteps_d = steps_q;
        if (is_load_q) tap_d[lane_q] = TAP_W'(INIT_TAP);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Pre-pulse decision shared by SETUP and the last GAP cycle.
    if (decide) begin
      if (cnt_q == '0) begin
        state_d = S_FINISH;
      end else if (blocked) begin
        st_d    = ST_RANGE;
        state_d = S_FINISH;
      end else begin
        state_d = S_PULSE;
      end
    end
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      state_q   <= S_IDLE;
      lane_q    <= '0;
      dir_q     <= 1'b0;
      is_load_q <= 1'b0;
      cnt_q     <= '0;
      steps_q   <= '0;
      hold_q    <= '0;
      st_q      <= ST_OK;
      tap_q     <= {NUM_LANES{TAP_W'(INIT_TAP)}};
      move_q    <= '0;
      dirl_q    <= '0;
      load_q    <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      dstat_q   <= ST_OK;
      dsteps_q  <= '0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      dir_q     <= dir_d;
      is_load_q <= is_load_d;
      cnt_q     <= cnt_d;
      steps_q   <= steps_d;
      hold_q    <= hold_d;
      st_q      <= st_d;
      tap_q     <= tap_d;
      move_q    <= move_d;
      dirl_q    <= dirl_d;
      load_q    <= load_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      dstat_q   <= dstat_d;
      dsteps_q  <= dsteps_d;
    end
  end

  assign CMD_READY            = ready_q;
  assign DONE                 = done_q;
  assign DONE_STATUS          = dstat_q;
  assign DONE_STEPS           = dsteps_q;
  assign TAP_VAL              = tap_q;
  assign DELAY_LINE_MOVE      = move_q;
  assign DELAY_LINE_DIRECTION = dirl_q;
  assign DELAY_LINE_LOAD      = load_q;

endmodule

// File: tb/tb_ddr_dly_line_ctrl.sv
// Randomized and directed bench for ddr_dly_line_ctrl against a per-command schedule model.
module tb_ddr_dly_line_ctrl;

  localparam int NL = 3, TW = 8, MAXT = 255, INIT = 1, GAP = 2, LC = 1;

  logic              clk = 1'b0;
  logic              rst, vld, rdy, dir_in, done;
  logic [1:0]        op, lane, dstat;
  logic [TW-1:0]     cnt, dsteps;
  logic [NL*TW-1:0]  tapv;
  logic [NL-1:0]     mv, dl, ld, oor;

  int checks = 0, errors = 0;
  int mtap[NL];
  logic [NL-1:0] mdir;

  always #5 clk = ~clk;

  ddr_dly_line_ctrl dut (
    .FAB_CLK(clk), .SYNC_RST(rst), .CMD_VALID(vld), .CMD_READY(rdy), .CMD_OP(op),
    .CMD_LANE(lane), .CMD_DIR(dir_in), .CMD_COUNT(cnt), .DONE(done), .DONE_STATUS(dstat),
    .DONE_STEPS(dsteps), .TAP_VAL(tapv), .DELAY_LINE_MOVE(mv), .DELAY_LINE_DIRECTION(dl),
    .DELAY_LINE_LOAD(ld), .DELAY_LINE_OUT_OF_RANGE(oor)
  );

  function automatic logic [NL*TW-1:0] model_taps();
    logic [NL*TW-1:0] v;
    for (int i = 0; i < NL; i++) v[i*TW +: TW] = TW'(mtap[i]);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) mtap[i] = INIT;
    mdir = '0;
  endtask

  // oor_at: cycle after whose sample the addressed lane's OUT_OF_RANGE rises (-1 = never).
  task automatic run_cmd(input logic [1:0] o, input logic [1:0] l, input logic d, input int n,
                         input int oor_at, input string nm);
    int steps, done_c, st, t, per;
    bit legal;
    logic [NL-1:0] oh, exp_mv, exp_ld;
    per = 1 + GAP;
    t = 0; steps = 0; st = 0;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL %s ready_idle got %b exp 1", nm, rdy); end
    vld = 1'b1; op = o; lane = l; dir_in = d; cnt = TW'(n);
    legal = (o[1] == 1'b0) && (int'(l) < NL);
    oh = legal ? (NL'(1) << l) : '0;
    if (!legal) begin
      st = 2; done_c = 1;
    end else if (o == 2'b00) begin
      done_c = 1 + LC;
    end else begin
      t = mtap[l];
      for (int i = 0; i < n; i++) begin
        if ((oor_at >= 0 && i * per >= oor_at) || (d && t == MAXT) || (!d && t == 0)) begin
          st = 1; break;
        end
        t += d ? 1 : -1;
        steps++;
      end
      done_c = 2 + steps * per;
    end
    @(posedge clk); #1;
    vld = 1'b0;
    if (oor_at == 0) oor = oh;
    for (int k = 1; k <= done_c; k++) begin
      @(posedge clk); #1;
      exp_mv = (legal && o == 2'b01 && k >= 2 && (k - 2) % per == 0 && (k - 2) / per < steps) ? oh : '0;
      exp_ld = (legal && o == 2'b00 && k <= LC) ? oh : '0;
      checks += 4;
      if (mv !== exp_mv) begin errors++; $display("FAIL %s move c%0d got %b exp %b", nm, k, mv, exp_mv); end
      if (ld !== exp_ld) begin errors++; $display("FAIL %s load c%0d got %b exp %b", nm, k, ld, exp_ld); end
      if (done !== (k == done_c)) begin errors++; $display("FAIL %s done c%0d got %b exp %b", nm, k, done, k == done_c); end
      if (rdy !== (k == done_c)) begin errors++; $display("FAIL %s ready c%0d got %b exp %b", nm, k, rdy, k == done_c); end
      if (k == oor_at) oor = oh;
    end
    oor = '0;
    if (legal && o == 2'b00) mtap[l] = INIT;
    if (legal && o == 2'b01) begin mtap[l] = t; mdir[l] = d; end
    checks += 4;
    if (dstat !== 2'(st)) begin errors++; $display("FAIL %s status got %0d exp %0d", nm, dstat, st); end
    if (dsteps !== TW'(steps)) begin errors++; $display("FAIL %s steps got %0d exp %0d", nm, dsteps, steps); end
    if (tapv !== model_taps()) begin errors++; $display("FAIL %s taps got %h exp %h", nm, tapv, model_taps()); end
    if (dl !== mdir) begin errors++; $display("FAIL %s direction got %b exp %b", nm, dl, mdir); end
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = 1'b0; op = '0; lane = '0; dir_in = 1'b0; cnt = '0; oor = '0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    checks += 6;
    if (rdy !== 1'b1) begin errors++; $display("FAIL reset ready got %b exp 1", rdy); end
    if (done !== 1'b0 || dstat !== 2'b00 || dsteps !== '0) begin
      errors++; $display("FAIL reset done got %b/%0d/%0d exp 0/0/0", done, dstat, dsteps);
    end
    if (mv !== '0) begin errors++; $display("FAIL reset move got %b exp 0", mv); end
    if (ld !== '0) begin errors++; $display("FAIL reset load got %b exp 0", ld); end
    if (dl !== '0) begin errors++; $display("FAIL reset direction got %b exp 0", dl); end
    if (tapv !== model_taps()) begin errors++; $display("FAIL reset taps got %h exp %h", tapv, model_taps()); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_move_basic();
    run_cmd(2'b01, 2'd0, 1'b1, 3, -1, "move_up3");
  endtask

  task automatic test_load();
    run_cmd(2'b00, 2'd2, 1'b0, 0, -1, "load_l2");
  endtask

  task automatic test_range_low();
    run_cmd(2'b01, 2'd2, 1'b0, 5, -1, "range_low");
  endtask

  task automatic test_oor();
    run_cmd(2'b01, 2'd1, 1'b1, 6, 5, "oor_after2");
    run_cmd(2'b01, 2'd1, 1'b0, 4, 0, "oor_at_setup");
  endtask

  task automatic test_illegal();
    run_cmd(2'b11, 2'd0, 1'b1, 4, -1, "illegal_op");
    run_cmd(2'b01, 2'd3, 1'b1, 4, -1, "illegal_lane");
    run_cmd(2'b01, 2'd1, 1'b1, 0, -1, "count_zero");
  endtask

  task automatic test_max_tap();
    run_cmd(2'b00, 2'd1, 1'b0, 0, -1, "max_load");
    run_cmd(2'b01, 2'd1, 1'b1, 255, -1, "max_up");
    run_cmd(2'b01, 2'd1, 1'b1, 2, -1, "max_again");
  endtask

  task automatic test_back_to_back();
    int r, o, l, n, oa;
    for (int c = 0; c < 25; c++) begin
      r = $urandom_range(0, 7);
      o = (r < 2) ? 0 : (r < 7) ? 1 : $urandom_range(2, 3);
      l = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      n = $urandom_range(0, 8);
      oa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
      run_cmd(2'(o), 2'(l), 1'($urandom_range(0, 1)), n, oa, "random");
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    vld = 1'b1; op = 2'b01; lane = 2'd0; dir_in = 1'b1; cnt = TW'(10);
    @(posedge clk); #1;
    vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    checks += 4;
    if (mv !== '0) begin errors++; $display("FAIL midrst move got %b exp 0", mv); end
    if (rdy !== 1'b1) begin errors++; $display("FAIL midrst ready got %b exp 1", rdy); end
    if (done !== 1'b0) begin errors++; $display("FAIL midrst done got %b exp 0", done); end
    if (tapv !== model_taps()) begin errors++; $display("FAIL midrst taps got %h exp %h", tapv, model_taps()); end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || mv !== '0) begin
        errors++; $display("FAIL midrst_quiet c%0d done %b move %b exp 0/0", k, done, mv);
      end
    end
    run_cmd(2'b01, 2'd0, 1'b1, 2, -1, "after_rst");
  endtask

  initial begin
    test_reset();
    test_move_basic();
    test_load();
    test_range_low();
    test_oor();
    test_illegal();
    test_max_tap();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
